// File: rtl/hirose_block_feeder.sv
`timescale 1ns/1ps
// Purpose: packs a byte stream into 64-bit big-endian blocks for a Hirose-PRESENT
//          core, appending 0x80/zero padding and a separate 64-bit bit-length block.
// Latency: a completed block appears on block_o one cycle after the byte that closes it.
// Backpressure: block_o/block_last_o hold until block_ready_i; byte_ready_o drops while
//          any block is pending, so the byte source stalls for the whole drain.
//
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   byte_i/_valid_i/_last_i, byte_ready_o - message byte stream (valid/ready)
//   empty_msg_i       - pulse requesting the hash of a zero-length message
//   block_o/_valid_o/_last_o, block_ready_i - block stream to the core (valid/ready)
//   busy_o            - a message is in flight
module hirose_block_feeder #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    input  logic                  byte_last_i,
    input  logic                  empty_msg_i,
    output logic                  byte_ready_o,
    output logic [DATA_WIDTH-1:0] block_o,
    output logic                  block_valid_o,
    output logic                  block_last_o,
    input  logic                  block_ready_i,
    output logic                  busy_o
);

    localparam logic [63:0] PAD_ONLY = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        SEND_DATA = 2'd1,
        SEND_PAD  = 2'd2,
        SEND_LEN  = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [60:0]  cnt_q, cnt_d;          // message length in bytes, wraps mod 2^61
    logic         pad_pend_q, pad_pend_d; // message ended exactly on a block boundary
    logic [63:0]  block_q, block_d;

    logic [2:0]   idx;                   // position of the next byte inside the block
    logic [2:0]   idx_nxt;
    logic         byte_acc;

    // The block position is the low bits of the byte count, so no separate index
    // register is needed; both are cleared together.
    assign idx     = cnt_q[2:0];
    assign idx_nxt = idx + 3'd1;

    // Gated with rst so the feeder never advertises readiness while held in reset.
    assign byte_ready_o  = rst && (state_q == COLLECT);
    assign byte_acc      = byte_valid_i && byte_ready_o;

    assign block_o       = block_q;
    assign block_valid_o = (state_q != COLLECT);
    assign block_last_o  = (state_q == SEND_LEN);
    assign busy_o        = (state_q != COLLECT) || (cnt_q != 61'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= COLLECT;
            cnt_q      <= '0;
            pad_pend_q <= 1'b0;
            block_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pad_pend_q <= pad_pend_d;
            block_q    <= block_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pad_pend_d = pad_pend_q;
        block_d    = block_q;

        case (state_q)
            COLLECT: begin
                if (byte_acc) begin
                    cnt_d = cnt_q + 61'd1;
                    // Big-endian packing: position 0 lands in bits [63:56].
                    for (int i = 0; i < 8; i++) begin
                        if (idx == 3'(i)) begin
                            block_d[63-8*i -: 8] = byte_i;
                        end
                    end
                    if (byte_last_i) begin
                        if (idx == 3'd7) begin
                            // Full data block first; the lone pad block follows it.
                            pad_pend_d = 1'b1;
                            state_d    = SEND_DATA;
                        end else begin
                            // Remaining positions are already zero because the block
                            // register is cleared after every handshake.
                            for (int i = 0; i < 8; i++) begin
                                if (idx_nxt == 3'(i)) begin
                                    block_d[63-8*i -: 8] = 8'h80;
                                end
                            end
                            state_d = SEND_PAD;
                        end
                    end else if (idx == 3'd7) begin
                        state_d = SEND_DATA;
                    end
                end else if (empty_msg_i && (cnt_q == 61'd0)) begin
                    block_d = PAD_ONLY;
                    state_d = SEND_PAD;
                end
            end

            SEND_DATA: begin
                if (block_ready_i) begin
                    if (pad_pend_q) begin
                        block_d    = PAD_ONLY;
                        pad_pend_d = 1'b0;
                        state_d    = SEND_PAD;
                    end else begin
                        block_d = '0;
                        state_d = COLLECT;
                    end
                end
            end

            SEND_PAD: begin
                if (block_ready_i) begin
                    // Bit length = byte count * 8, naturally modulo 2^64.
                    block_d = {cnt_q, 3'b000};
                    state_d = SEND_LEN;
                end
            end

            SEND_LEN: begin
                if (block_ready_i) begin
                    cnt_d      = '0;
                    block_d    = '0;
                    pad_pend_d = 1'b0;
                    state_d    = COLLECT;
                end
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

endmodule

// File: tb/tb_hirose_block_feeder.sv
`timescale 1ns/1ps
module tb_hirose_block_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_last_i;
    logic        empty_msg_i;
    logic        byte_ready_o;
    logic [63:0] block_o;
    logic        block_valid_o;
    logic        block_last_o;
    logic        block_ready_i;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    logic [64:0] out_q[$];   // {last, block} for every handshake observed
    logic [64:0] exp_q[$];   // reference expectation
    logic [7:0]  msg_q[$];   // message currently being sent

    bit stall   = 1'b0;
    bit rnd_rdy = 1'b0;

    hirose_block_feeder #(.DATA_WIDTH(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .byte_i        (byte_i),
        .byte_valid_i  (byte_valid_i),
        .byte_last_i   (byte_last_i),
        .empty_msg_i   (empty_msg_i),
        .byte_ready_o  (byte_ready_o),
        .block_o       (block_o),
        .block_valid_o (block_valid_o),
        .block_last_o  (block_last_o),
        .block_ready_i (block_ready_i),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    // Inputs only change shortly after posedge, so the negedge view equals the
    // values the DUT sees at the next rising edge.
    always @(negedge clk) begin
        if (rst && block_valid_o && block_ready_i)
            out_q.push_back({block_last_o, block_o});
    end

    initial begin
        block_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            block_ready_i = stall ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: append 0x80, zero-fill to a multiple of 8 bytes, cut into
    // big-endian words, then one block holding the bit length.
    task automatic build_expected();
        logic [7:0]  p[$];
        logic [63:0] w;
        p = msg_q;
        p.push_back(8'h80);
        while ((p.size() % 8) != 0) p.push_back(8'h00);
        exp_q.delete();
        for (int k = 0; k < p.size(); k += 8) begin
            w = {p[k], p[k+1], p[k+2], p[k+3], p[k+4], p[k+5], p[k+6], p[k+7]};
            exp_q.push_back({1'b0, w});
        end
        exp_q.push_back({1'b1, 64'(msg_q.size()) * 64'd8});
    endtask

    // Called and returns at posedge+1. rnd_valid inserts idle cycles carrying junk
    // byte/last values that must be ignored.
    task automatic send_bytes(input bit rnd_valid, input bit mark_last);
        int i = 0;
        int guard = 0;
        while (i < msg_q.size() && guard < 1000) begin
            bit acc;
            if (rnd_valid && $urandom_range(0, 2) == 0) begin
                byte_valid_i = 1'b0;
                byte_i       = 8'($urandom);
                byte_last_i  = 1'($urandom);
            end else begin
                byte_valid_i = 1'b1;
                byte_i       = msg_q[i];
                byte_last_i  = mark_last && (i == msg_q.size() - 1);
            end
            @(negedge clk);
            acc = byte_valid_i && byte_ready_o;
            @(posedge clk);
            #1;
            if (acc) i++;
            guard++;
        end
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        check("send_progress", 65'(i), 65'(msg_q.size()));
    endtask

    task automatic wait_done(input int n);
        int g = 0;
        while ((out_q.size() < n || busy_o !== 1'b0) && g < 400) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain_in_time", 65'(g < 400), 65'd1);
    endtask

    task automatic compare_out(input string tag);
        check({tag, "_count"}, 65'(out_q.size()), 65'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            check($sformatf("%s_blk%0d", tag, k),
                  (k < out_q.size()) ? out_q[k] : 65'bx, exp_q[k]);
    endtask

    initial begin
        rst          = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        empty_msg_i  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_ready", 65'(byte_ready_o), 65'd0);
        check("rst_block_valid", 65'(block_valid_o), 65'd0);
        check("rst_block_last", 65'(block_last_o), 65'd0);
        check("rst_busy", 65'(busy_o), 65'd0);
        check("rst_block", 65'(block_o), 65'd0);
        rst = 1'b1;
        #1;
        check("post_rst_ready", 65'(byte_ready_o), 65'd1);
        @(posedge clk);
        #1;

        // "abc"
        out_q.delete();
        msg_q = '{8'h61, 8'h62, 8'h63};
        build_expected();
        send_bytes(1'b0, 1'b1);
        check("abc_lat_valid", 65'(block_valid_o), 65'd1);
        check("abc_lat_block", 65'(block_o), 65'h6162638000000000);
        check("abc_lat_last", 65'(block_last_o), 65'd0);
        check("abc_lat_ready", 65'(byte_ready_o), 65'd0);
        check("abc_lat_busy", 65'(busy_o), 65'd1);
        wait_done(2);
        compare_out("abc");
        check("abc_idle_ready", 65'(byte_ready_o), 65'd1);

        // Exactly one full block, last byte on the boundary
        out_q.delete();
        msg_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        build_expected();
        send_bytes(1'b0, 1'b1);
        wait_done(3);
        compare_out("eight");

        // Zero-length message
        out_q.delete();
        msg_q.delete();
        build_expected();
        empty_msg_i = 1'b1;
        @(posedge clk);
        #1;
        empty_msg_i = 1'b0;
        check("empty_busy", 65'(busy_o), 65'd1);
        check("empty_pad_block", 65'(block_o), 65'h8000000000000000);
        wait_done(2);
        compare_out("empty");

        // Nine bytes with the core stalling for five cycles on the first block
        out_q.delete();
        stall = 1'b1;
        msg_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        send_bytes(1'b0, 1'b0);
        byte_valid_i = 1'b1;
        byte_i       = 8'h19;
        byte_last_i  = 1'b1;
        empty_msg_i  = 1'b1;   // must be ignored while a block is pending
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall_block_c%0d", c), 65'(block_o), 65'h1112131415161718);
            check($sformatf("stall_valid_c%0d", c), 65'(block_valid_o), 65'd1);
            check($sformatf("stall_ready_c%0d", c), 65'(byte_ready_o), 65'd0);
            @(posedge clk);
            #1;
            empty_msg_i = 1'b0;
        end
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        stall = 1'b0;
        msg_q = '{8'h19};
        send_bytes(1'b0, 1'b1);
        msg_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
        build_expected();
        wait_done(3);
        compare_out("stall");

        // Reset in the middle of a message discards it
        out_q.delete();
        msg_q.delete();
        for (int k = 0; k < 5; k++) msg_q.push_back(8'($urandom));
        send_bytes(1'b0, 1'b0);
        check("pre_rst_busy", 65'(busy_o), 65'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 65'(busy_o), 65'd0);
        check("mid_rst_ready", 65'(byte_ready_o), 65'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check("mid_rst_no_output", 65'(out_q.size()), 65'd0);
        msg_q = '{8'h61, 8'h62, 8'h63};
        build_expected();
        send_bytes(1'b0, 1'b1);
        wait_done(2);
        compare_out("after_rst");

        // Randomised messages with random valid gaps and random core readiness
        rnd_rdy = 1'b1;
        for (int r = 0; r < 4; r++) begin
            int len;
            len = (r == 0) ? 16 : int'($urandom_range(1, 20));
            msg_q.delete();
            for (int k = 0; k < len; k++) msg_q.push_back(8'($urandom));
            build_expected();
            out_q.delete();
            send_bytes(1'b1, 1'b1);
            wait_done(exp_q.size());
            compare_out($sformatf("rand%0d", r));
        end
        rnd_rdy = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
